rf_writeback_queue: RTL and testbench

//   Write-side initiator for the 64-bit 32-entry register file. Buffers

---
 rtl/rf_writeback_queue.sv | 106 ++++++++++
 tb/tb_rf_writeback_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_queue.sv
// In-order writeback queue feeding the register file write port, with
// youngest-match forwarding of pending results to the decode read ports.
module rf_writeback_queue #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [4:0]                   in_idx,
    input  logic [XLEN-1:0]              in_data,
    input  logic                         rf_wr_ready,
    output logic                         rf_wr_en,
    output logic [4:0]                   rf_wr_idx,
    output logic [XLEN-1:0]              rf_wr_data,
    input  logic [4:0]                   fwd_idx1,
    input  logic [4:0]                   fwd_idx2,
    output logic                         fwd_hit1,
    output logic                         fwd_hit2,
    output logic [XLEN-1:0]              fwd_data1,
    output logic [XLEN-1:0]              fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [4:0]       idx_q  [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_s;
    logic             pop_s;
    logic [PTR_W-1:0] fwd_slot_s;
    logic             live_s;
    logic             match1_s;
    logic             match2_s;

    // Handshake, pointer and occupancy next-state; x0 results are accepted but dropped.
    always_comb begin
        pop_s    = (count_q != {CNT_W{1'b0}}) && rf_wr_ready;
        in_ready = (count_q < CNT_W'(DEPTH)) || pop_s;
        push_s   = in_valid && in_ready && (in_idx != 5'd0);
        head_d   = pop_s  ? head_q + PTR_W'(1) : head_q;
        tail_d   = push_s ? tail_q + PTR_W'(1) : tail_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue storage and pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i]  <= 5'd0;
                data_q[i] <= {XLEN{1'b0}};
            end
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_s) begin
                idx_q[tail_q]  <= in_idx;
                data_q[tail_q] <= in_data;
            end
        end
    end

    // Write port presents the head entry straight from storage, zero when empty.
    always_comb begin
        rf_wr_en   = (count_q != {CNT_W{1'b0}});
        rf_wr_idx  = rf_wr_en ? idx_q[head_q]  : 5'd0;
        rf_wr_data = rf_wr_en ? data_q[head_q] : {XLEN{1'b0}};
        count      = count_q;
    end

    // Forwarding: scan oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        fwd_hit1   = 1'b0;
        fwd_hit2   = 1'b0;
        fwd_data1  = {XLEN{1'b0}};
        fwd_data2  = {XLEN{1'b0}};
        fwd_slot_s = head_q;
        live_s     = 1'b0;
        match1_s   = 1'b0;
        match2_s   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_slot_s = head_q + PTR_W'(i);
            live_s     = (CNT_W'(i) < count_q);
            match1_s   = live_s && (fwd_idx1 != 5'd0) && (idx_q[fwd_slot_s] == fwd_idx1);
            match2_s   = live_s && (fwd_idx2 != 5'd0) && (idx_q[fwd_slot_s] == fwd_idx2);
            fwd_hit1   = fwd_hit1 | match1_s;
            fwd_hit2   = fwd_hit2 | match2_s;
            fwd_data1  = match1_s ? data_q[fwd_slot_s] : fwd_data1;
            fwd_data2  = match2_s ? data_q[fwd_slot_s] : fwd_data2;
        end
    end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed vector table plus reset-abort and pointer-wrap sequences for
// rf_writeback_queue.
module tb_rf_writeback_queue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_idx;
    logic [63:0] in_data;
    logic        rf_wr_ready;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_idx;
    logic [63:0] rf_wr_data;
    logic [4:0]  fwd_idx1;
    logic [4:0]  fwd_idx2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [63:0] fwd_data1;
    logic [63:0] fwd_data2;
    logic [2:0]  count;

    int tests_run;
    int tests_failed;

    rf_writeback_queue #(.XLEN(64), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_data(in_data),
        .rf_wr_ready(rf_wr_ready), .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx),
        .rf_wr_data(rf_wr_data), .fwd_idx1(fwd_idx1), .fwd_idx2(fwd_idx2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1),
        .fwd_data2(fwd_data2), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  ii;
        logic [63:0] id;
        logic        rr;
        logic [4:0]  f1;
        logic [4:0]  f2;
        logic        e_ir;
        logic        e_en;
        logic [4:0]  e_idx;
        logic [63:0] e_data;
        logic        e_h1;
        logic [63:0] e_d1;
        logic        e_h2;
        logic [63:0] e_d2;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[32];
    int   nvec;

    task automatic add(input logic iv, input logic [4:0] ii, input logic [63:0] id,
                       input logic rr, input logic [4:0] f1, input logic [4:0] f2,
                       input logic ir, input logic en, input logic [4:0] idx,
                       input logic [63:0] data, input logic h1, input logic [63:0] d1,
                       input logic h2, input logic [63:0] d2, input logic [2:0] cnt);
        vecs[nvec] = '{iv, ii, id, rr, f1, f2, ir, en, idx, data, h1, d1, h2, d2, cnt};
        nvec++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic [4:0]  exp_idx_q[$];
    logic [63:0] exp_dat_q[$];
    logic [4:0]  itm_idx[9];
    logic [63:0] itm_dat[9];
    int          sent;
    int          written;
    int          mcount;
    int          cyc;
    logic        exp_ir;
    logic        push_m;
    logic        pop_m;

    initial begin
        tests_run = 0;
        tests_failed = 0;
        nvec = 0;
        // iv ii id rr f1 f2 | ir en idx data h1 d1 h2 d2 cnt
        add(1'b0, 5'd0, 64'h0,  1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h0,  3'd0);
        add(1'b1, 5'd5, 64'hA5, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h0,  3'd0);
        add(1'b0, 5'd0, 64'h0,  1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 64'hA5, 1'b1, 64'hA5, 1'b0, 64'h0,  3'd1);
        add(1'b0, 5'd0, 64'h0,  1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h0,  3'd0);
        add(1'b1, 5'd0, 64'hFF, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h0,  3'd0);
        add(1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h0,  3'd0);
        add(1'b1, 5'd1, 64'h11, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h0,  3'd0);
        add(1'b1, 5'd2, 64'h22, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 64'h11, 1'b0, 64'h0,  1'b0, 64'h0,  3'd1);
        add(1'b1, 5'd3, 64'h33, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 64'h11, 1'b0, 64'h0,  1'b0, 64'h0,  3'd2);
        add(1'b1, 5'd4, 64'h44, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 64'h11, 1'b0, 64'h0,  1'b0, 64'h0,  3'd3);
        add(1'b1, 5'd5, 64'h55, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd1, 64'h11, 1'b0, 64'h0,  1'b0, 64'h0,  3'd4);
        add(1'b1, 5'd5, 64'h55, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd1, 64'h11, 1'b0, 64'h0,  1'b0, 64'h0,  3'd4);
        add(1'b1, 5'd5, 64'h55, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 64'h11, 1'b0, 64'h0,  1'b0, 64'h0,  3'd4);
        add(1'b0, 5'd0, 64'h0,  1'b0, 5'd5, 5'd2, 1'b0, 1'b1, 5'd2, 64'h22, 1'b1, 64'h55, 1'b1, 64'h22, 3'd4);
        add(1'b0, 5'd0, 64'h0,  1'b1, 5'd2, 5'd0, 1'b1, 1'b1, 5'd2, 64'h22, 1'b1, 64'h22, 1'b0, 64'h0,  3'd4);
        add(1'b0, 5'd0, 64'h0,  1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 64'h33, 1'b0, 64'h0,  1'b0, 64'h0,  3'd3);
        add(1'b0, 5'd0, 64'h0,  1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 64'h44, 1'b0, 64'h0,  1'b0, 64'h0,  3'd2);
        add(1'b0, 5'd0, 64'h0,  1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 64'h55, 1'b0, 64'h0,  1'b0, 64'h0,  3'd1);
        add(1'b0, 5'd0, 64'h0,  1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h0,  3'd0);
        add(1'b1, 5'd7, 64'h1,  1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h0,  3'd0);
        add(1'b1, 5'd7, 64'h2,  1'b0, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 64'h1,  1'b1, 64'h1,  1'b0, 64'h0,  3'd1);
        add(1'b0, 5'd0, 64'h0,  1'b0, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 64'h1,  1'b1, 64'h2,  1'b0, 64'h0,  3'd2);
        add(1'b0, 5'd0, 64'h0,  1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 64'h1,  1'b1, 64'h2,  1'b0, 64'h0,  3'd2);
        add(1'b0, 5'd0, 64'h0,  1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 64'h2,  1'b1, 64'h2,  1'b0, 64'h0,  3'd1);
        add(1'b0, 5'd0, 64'h0,  1'b1, 5'd7, 5'd7, 1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h0,  3'd0);

        reset = 1'b0;
        in_valid = 1'b0;
        in_idx = 5'd0;
        in_data = 64'h0;
        rf_wr_ready = 1'b0;
        fwd_idx1 = 5'd0;
        fwd_idx2 = 5'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < nvec; v++) begin
            @(negedge clk);
            in_valid    = vecs[v].iv;
            in_idx      = vecs[v].ii;
            in_data     = vecs[v].id;
            rf_wr_ready = vecs[v].rr;
            fwd_idx1    = vecs[v].f1;
            fwd_idx2    = vecs[v].f2;
            #1;
            chk($sformatf("v%0d in_ready", v),   {63'd0, in_ready},   {63'd0, vecs[v].e_ir});
            chk($sformatf("v%0d rf_wr_en", v),   {63'd0, rf_wr_en},   {63'd0, vecs[v].e_en});
            chk($sformatf("v%0d rf_wr_idx", v),  {59'd0, rf_wr_idx},  {59'd0, vecs[v].e_idx});
            chk($sformatf("v%0d rf_wr_data", v), rf_wr_data,          vecs[v].e_data);
            chk($sformatf("v%0d fwd_hit1", v),   {63'd0, fwd_hit1},   {63'd0, vecs[v].e_h1});
            chk($sformatf("v%0d fwd_data1", v),  fwd_data1,           vecs[v].e_d1);
            chk($sformatf("v%0d fwd_hit2", v),   {63'd0, fwd_hit2},   {63'd0, vecs[v].e_h2});
            chk($sformatf("v%0d fwd_data2", v),  fwd_data2,           vecs[v].e_d2);
            chk($sformatf("v%0d count", v),      {61'd0, count},      {61'd0, vecs[v].e_cnt});
        end

        // Mid-operation reset: three stalled entries must vanish without a write.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_idx = 5'(9 + k);
            in_data = 64'(100 + k);
            rf_wr_ready = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        fwd_idx1 = 5'd9;
        fwd_idx2 = 5'd0;
        #1;
        chk("prefill count", {61'd0, count}, 64'd3);
        #1;
        reset = 1'b0;
        #1;
        chk("arst rf_wr_en", {63'd0, rf_wr_en}, 64'd0);
        chk("arst count", {61'd0, count}, 64'd0);
        chk("arst in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst fwd_hit1", {63'd0, fwd_hit1}, 64'd0);
        chk("arst rf_wr_data", rf_wr_data, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        rf_wr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post-rst %0d rf_wr_en", k), {63'd0, rf_wr_en}, 64'd0);
            chk($sformatf("post-rst %0d count", k), {61'd0, count}, 64'd0);
        end

        // Pointer wrap: 2*DEPTH+1 entries under random write-port grants.
        for (int k = 0; k < 9; k++) begin
            itm_idx[k] = 5'((k % 31) + 1);
            itm_dat[k] = {$urandom, $urandom};
        end
        sent = 0;
        written = 0;
        mcount = 0;
        cyc = 0;
        while ((sent < 9 || written < 9) && cyc < 200) begin
            @(negedge clk);
            rf_wr_ready = 1'($urandom_range(0, 1));
            in_valid = (sent < 9);
            in_idx = (sent < 9) ? itm_idx[sent] : 5'd0;
            in_data = (sent < 9) ? itm_dat[sent] : 64'h0;
            #1;
            pop_m = (mcount != 0) && rf_wr_ready;
            exp_ir = (mcount < 4) || pop_m;
            push_m = in_valid && exp_ir;
            chk($sformatf("wrap c%0d in_ready", cyc), {63'd0, in_ready}, {63'd0, exp_ir});
            chk($sformatf("wrap c%0d count", cyc), {61'd0, count}, 64'(mcount));
            chk($sformatf("wrap c%0d rf_wr_en", cyc), {63'd0, rf_wr_en}, {63'd0, (mcount != 0)});
            if (pop_m) begin
                chk($sformatf("wrap w%0d idx", written), {59'd0, rf_wr_idx}, {59'd0, exp_idx_q[0]});
                chk($sformatf("wrap w%0d data", written), rf_wr_data, exp_dat_q[0]);
                void'(exp_idx_q.pop_front());
                void'(exp_dat_q.pop_front());
                written++;
                mcount--;
            end
            if (push_m) begin
                exp_idx_q.push_back(itm_idx[sent]);
                exp_dat_q.push_back(itm_dat[sent]);
                sent++;
                mcount++;
            end
            cyc++;
        end
        chk("wrap writes completed", 64'(written), 64'd9);
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
